// File: rtl/sched_deq_rr_arbiter.sv
// Round-robin dequeue arbiter: one outstanding dequeue request shared across
// several PIEO instances, with result hold, timeout and all-ones drop handling.
//
// state | meaning
// IDLE  | no request outstanding; grant the next eligible PIEO
// WAIT  | trigger issued; waiting for the granted PIEO's result
// HOLD  | result offered downstream until accepted
module sched_deq_rr_arbiter #(
  parameter int NUM_PIEO      = 4,
  parameter int ELEMENT_WIDTH = 8,
  parameter int TIMEOUT       = 15,
  localparam int IDX_W        = (NUM_PIEO > 1) ? $clog2(NUM_PIEO) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PIEO-1:0]               pieo_ready_for_deq,
  input  logic [NUM_PIEO-1:0]               pieo_empty,
  output logic [NUM_PIEO-1:0]               pieo_deq_trigger_out,
  input  logic [NUM_PIEO-1:0]               deq_valid_in,
  input  logic [NUM_PIEO*ELEMENT_WIDTH-1:0] deq_element_in,
  input  logic                              post_deq_ready,
  output logic                              deq_valid_out,
  output logic [ELEMENT_WIDTH-1:0]          deq_element_out,
  output logic [IDX_W-1:0]                  deq_src_out,
  output logic                              timeout_pulse,
  output logic [15:0]                       drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [7:0]               wait_cnt_q, wait_cnt_d;
  logic [ELEMENT_WIDTH-1:0] hold_elem_q, hold_elem_d;
  logic [IDX_W-1:0]         hold_src_q, hold_src_d;
  logic [15:0]              drop_count_q, drop_count_d;
  logic                     timeout_q, timeout_d;

  logic [NUM_PIEO-1:0]      eligible;
  logic [NUM_PIEO-1:0]      trig_vec;
  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         cand;
  logic [ELEMENT_WIDTH-1:0] grant_elem;

  assign eligible   = pieo_ready_for_deq & ~pieo_empty;
  assign grant_elem = deq_element_in[int'(grant_q)*ELEMENT_WIDTH +: ELEMENT_WIDTH];

  // Scan from rr_ptr upward with wrap; first eligible index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr_q;
    for (int i = 0; i < NUM_PIEO; i++) begin
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == IDX_W'(NUM_PIEO - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    wait_cnt_d   = wait_cnt_q;
    hold_elem_d  = hold_elem_q;
    hold_src_d   = hold_src_q;
    drop_count_d = drop_count_q;
    timeout_d    = 1'b0;
    trig_vec     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          trig_vec[pick_idx] = 1'b1;
          grant_d            = pick_idx;
          rr_ptr_d           = (pick_idx == IDX_W'(NUM_PIEO - 1)) ? '0 : pick_idx + 1'b1;
          wait_cnt_d         = '0;
          state_d            = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving on the timeout cycle still wins.
        if (deq_valid_in[grant_q]) begin
          if (&grant_elem) begin
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            hold_elem_d = grant_elem;
            hold_src_d  = grant_q;
            state_d     = ST_HOLD;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == 8'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (post_deq_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      wait_cnt_q   <= '0;
      hold_elem_q  <= '0;
      hold_src_q   <= '0;
      drop_count_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_elem_q  <= hold_elem_d;
      hold_src_q   <= hold_src_d;
      drop_count_q <= drop_count_d;
      timeout_q    <= timeout_d;
    end
  end

  // Outputs are forced low while rst is asserted, even before the reset edge.
  assign pieo_deq_trigger_out = rst ? '0 : trig_vec;
  assign deq_valid_out        = ~rst & (state_q == ST_HOLD);
  assign deq_element_out      = deq_valid_out ? hold_elem_q : '0;
  assign deq_src_out          = deq_valid_out ? hold_src_q : '0;
  assign timeout_pulse        = ~rst & timeout_q;
  assign drop_count           = rst ? 16'd0 : drop_count_q;

endmodule

// File: tb/tb_sched_deq_rr_arbiter.sv
// Scoreboard bench for sched_deq_rr_arbiter: a small PIEO response model pushes
// expected {src, element} when it returns a result; transfers pop and compare.
module tb_sched_deq_rr_arbiter;
  localparam int N  = 4;
  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    pieo_ready_for_deq, pieo_empty, pieo_deq_trigger_out, deq_valid_in;
  logic [N*EW-1:0] deq_element_in;
  logic            post_deq_ready, deq_valid_out, timeout_pulse;
  logic [EW-1:0]   deq_element_out;
  logic [1:0]      deq_src_out;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  sched_deq_rr_arbiter #(.NUM_PIEO(N), .ELEMENT_WIDTH(EW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .pieo_ready_for_deq(pieo_ready_for_deq), .pieo_empty(pieo_empty),
    .pieo_deq_trigger_out(pieo_deq_trigger_out),
    .deq_valid_in(deq_valid_in), .deq_element_in(deq_element_in),
    .post_deq_ready(post_deq_ready), .deq_valid_out(deq_valid_out),
    .deq_element_out(deq_element_out), .deq_src_out(deq_src_out),
    .timeout_pulse(timeout_pulse), .drop_count(drop_count)
  );

  int vectors = 0, miscompares = 0, cyc = 0, xfer_cnt = 0;
  logic [N-1:0]  s_trig;
  logic          s_vout, s_tp;
  logic [EW-1:0] s_elem;
  logic [1:0]    s_src;
  logic [15:0]   s_drop;

  int            auto_lat = 0;
  logic          pend = 1'b0;
  int            pend_cnt = 0, pend_src = 0;
  logic [EW-1:0] elem_val [N];
  logic [EW+1:0] sb [$];

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: sample at negedge, then model PIEO results just after posedge.
  task automatic tick();
    logic [EW+1:0] exp_v;
    @(negedge clk);
    cyc++;
    s_trig = pieo_deq_trigger_out; s_vout = deq_valid_out; s_tp = timeout_pulse;
    s_elem = deq_element_out; s_src = deq_src_out; s_drop = drop_count;
    vectors++;
    if ($countones(s_trig) > 1) begin
      miscompares++; $display("FAIL trig_onehot trigger=%b required at most one bit", s_trig);
    end
    if (s_vout && post_deq_ready) begin
      vectors++; xfer_cnt++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected src=%0d elem=%h required no output", s_src, s_elem);
      end else begin
        exp_v = sb.pop_front();
        if ({s_src, s_elem} !== exp_v) begin
          miscompares++;
          $display("FAIL sb_output src=%0d elem=%h required src=%0d elem=%h",
                   s_src, s_elem, exp_v[EW+1:EW], exp_v[EW-1:0]);
        end
      end
    end
    if (s_trig != 0 && auto_lat > 0) begin
      pend = 1'b1; pend_src = oh_idx(s_trig); pend_cnt = auto_lat;
    end
    @(posedge clk); #1;
    deq_valid_in = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend = 1'b0;
        deq_valid_in[pend_src] = 1'b1;
        deq_element_in[pend_src*EW +: EW] = elem_val[pend_src];
        if (elem_val[pend_src] != '1) sb.push_back({2'(pend_src), elem_val[pend_src]});
      end
    end
  endtask

  task automatic wait_trig(input int bound);
    int n = 0;
    do begin tick(); n++; end while (s_trig == 0 && n < bound);
  endtask

  task automatic wait_vout(input int bound);
    int n = 0;
    do begin tick(); n++; end while (!s_vout && n < bound);
  endtask

  task automatic test_reset();
    rst = 1'b1; pieo_ready_for_deq = '1; pieo_empty = '0; deq_valid_in = '0;
    deq_element_in = '0; post_deq_ready = 1'b0;
    repeat (2) begin
      tick(); vectors++;
      if ({s_trig, s_vout, s_tp, s_elem, s_src, s_drop} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs trig=%b vout=%b tp=%b elem=%h src=%0d drop=%0d required all zero",
                 s_trig, s_vout, s_tp, s_elem, s_src, s_drop);
      end
    end
    pieo_ready_for_deq = '0; rst = 1'b0;
    tick(); vectors++;
    if (s_trig !== '0 || s_vout !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_eligible trig=%b vout=%b required 0 0", s_trig, s_vout);
    end
  endtask

  task automatic test_round_robin();
    int g[$], gc[$];
    int n = 0, x0 = xfer_cnt;
    pieo_ready_for_deq = '1; pieo_empty = '0; post_deq_ready = 1'b1; auto_lat = 2;
    for (int i = 0; i < N; i++) elem_val[i] = 8'hA0 + 8'(i);
    while (g.size() < 5 && n < 60) begin
      tick(); n++;
      if (s_trig != 0) begin g.push_back(oh_idx(s_trig)); gc.push_back(cyc); end
    end
    pieo_ready_for_deq = '0;
    repeat (6) tick();
    vectors++;
    if (g.size() !== 5) begin
      miscompares++; $display("FAIL rr_grant_count got=%0d required 5", g.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (g[i] !== i % 4) begin
          miscompares++; $display("FAIL rr_grant_order[%0d] got=%0d required %0d", i, g[i], i % 4);
        end
        if (i > 0) begin
          vectors++;
          if (gc[i] - gc[i-1] !== 4) begin
            miscompares++; $display("FAIL rr_spacing[%0d] got=%0d required 4", i, gc[i] - gc[i-1]);
          end
        end
      end
    end
    vectors++;
    if (xfer_cnt - x0 !== 5) begin
      miscompares++; $display("FAIL rr_outputs got=%0d required 5", xfer_cnt - x0);
    end
  endtask

  task automatic test_drop();
    int g[$], gc[$];
    int n = 0, vcnt = 0;
    logic [15:0] d_at2 = '0;
    pieo_ready_for_deq = '1; pieo_empty = 4'b1011; auto_lat = 2; elem_val[2] = 8'hFF;
    while (g.size() < 2 && n < 30) begin
      tick(); n++;
      if (s_vout) vcnt++;
      if (s_trig != 0) begin g.push_back(oh_idx(s_trig)); gc.push_back(cyc); d_at2 = s_drop; end
    end
    pieo_ready_for_deq = '0;
    repeat (4) begin tick(); if (s_vout) vcnt++; end
    vectors++;
    if (g.size() !== 2) begin
      miscompares++; $display("FAIL drop_grants got=%0d required 2", g.size());
    end else begin
      vectors++;
      if (g[0] !== 2 || g[1] !== 2 || gc[1] - gc[0] !== 3) begin
        miscompares++;
        $display("FAIL drop_regrant got=%0d,%0d gap=%0d required 2,2 gap=3", g[0], g[1], gc[1] - gc[0]);
      end
      vectors++;
      if (d_at2 !== 16'd1) begin
        miscompares++; $display("FAIL drop_count_first got=%0d required 1", d_at2);
      end
    end
    vectors++;
    if (s_drop !== 16'd2 || vcnt !== 0) begin
      miscompares++; $display("FAIL drop_final drop=%0d vout_cycles=%0d required 2 0", s_drop, vcnt);
    end
    pieo_empty = '0;
  endtask

  task automatic test_timeout();
    int t0, n = 0, tp_n = 0, tp_c = -1;
    pieo_ready_for_deq = 4'b0010; auto_lat = 0; post_deq_ready = 1'b1;
    wait_trig(10);
    t0 = cyc;
    vectors++;
    if (s_trig !== 4'b0010) begin
      miscompares++; $display("FAIL tmo_first_grant trig=%b required 0010", s_trig);
    end
    pieo_ready_for_deq = 4'b0110; auto_lat = 2; elem_val[2] = 8'h5A;
    do begin
      tick(); n++;
      if (s_tp) begin tp_n++; tp_c = cyc; end
    end while (s_trig == 0 && n < 40);
    vectors++;
    if (s_trig !== 4'b0100 || cyc - t0 !== 16 || tp_c !== t0 + 16) begin
      miscompares++;
      $display("FAIL tmo_regrant trig=%b at=%0d pulse_at=%0d required 0100 at=16 pulse_at=16",
               s_trig, cyc - t0, tp_c - t0);
    end
    pieo_ready_for_deq = '0;
    repeat (6) begin tick(); if (s_tp) tp_n++; end
    vectors++;
    if (tp_n !== 1) begin
      miscompares++; $display("FAIL tmo_pulse_count got=%0d required 1", tp_n);
    end
  endtask

  task automatic test_hold();
    pieo_ready_for_deq = 4'b1000; auto_lat = 2; elem_val[3] = 8'h3C; post_deq_ready = 1'b0;
    wait_trig(10);
    vectors++;
    if (s_trig !== 4'b1000) begin
      miscompares++; $display("FAIL hold_grant trig=%b required 1000", s_trig);
    end
    pieo_ready_for_deq = '1;
    wait_vout(10);
    vectors++;
    if (s_vout !== 1'b1) begin
      miscompares++; $display("FAIL hold_reach vout=%b required 1", s_vout);
    end
    repeat (5) begin
      tick(); vectors++;
      if (s_vout !== 1'b1 || s_elem !== 8'h3C || s_src !== 2'd3 || s_trig !== '0) begin
        miscompares++;
        $display("FAIL hold_stable vout=%b elem=%h src=%0d trig=%b required 1 3c 3 0000",
                 s_vout, s_elem, s_src, s_trig);
      end
    end
    post_deq_ready = 1'b1;
    tick(); vectors++;
    if (s_vout !== 1'b1 || s_trig !== '0) begin
      miscompares++; $display("FAIL hold_xfer vout=%b trig=%b required 1 0000", s_vout, s_trig);
    end
    tick(); vectors++;
    if (s_trig !== 4'b0001) begin
      miscompares++; $display("FAIL hold_next_grant trig=%b required 0001", s_trig);
    end
    pieo_ready_for_deq = '0;
    repeat (5) tick();
  endtask

  task automatic test_spurious();
    pieo_ready_for_deq = 4'b0001; auto_lat = 0; post_deq_ready = 1'b1;
    wait_trig(10);
    vectors++;
    if (s_trig !== 4'b0001) begin
      miscompares++; $display("FAIL spur_grant trig=%b required 0001", s_trig);
    end
    pieo_ready_for_deq = '0;
    deq_valid_in[3] = 1'b1; deq_element_in[3*EW +: EW] = 8'h77;
    tick(); vectors++;
    if (s_vout !== 1'b0) begin
      miscompares++; $display("FAIL spur_ignored_a vout=%b required 0", s_vout);
    end
    deq_valid_in[0] = 1'b1; deq_element_in[0 +: EW] = 8'h42; sb.push_back({2'd0, 8'h42});
    tick(); vectors++;
    if (s_vout !== 1'b0) begin
      miscompares++; $display("FAIL spur_ignored_b vout=%b required 0", s_vout);
    end
    tick(); vectors++;
    if (s_vout !== 1'b1 || s_src !== 2'd0 || s_elem !== 8'h42) begin
      miscompares++;
      $display("FAIL spur_forward vout=%b src=%0d elem=%h required 1 0 42", s_vout, s_src, s_elem);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_in_hold();
    pieo_ready_for_deq = 4'b0100; elem_val[2] = 8'h66; auto_lat = 2; post_deq_ready = 1'b0;
    wait_trig(10);
    vectors++;
    if (s_trig !== 4'b0100) begin
      miscompares++; $display("FAIL rsth_grant trig=%b required 0100", s_trig);
    end
    pieo_ready_for_deq = '0;
    wait_vout(10);
    vectors++;
    if (s_vout !== 1'b1) begin
      miscompares++; $display("FAIL rsth_reach vout=%b required 1", s_vout);
    end
    sb.delete();
    rst = 1'b1; pieo_ready_for_deq = '1;
    tick(); vectors++;
    if (s_vout !== 1'b0 || s_trig !== '0 || s_drop !== 16'd0) begin
      miscompares++;
      $display("FAIL rsth_during vout=%b trig=%b drop=%0d required 0 0000 0", s_vout, s_trig, s_drop);
    end
    rst = 1'b0;
    tick(); vectors++;
    if (s_trig !== 4'b0001 || s_vout !== 1'b0) begin
      miscompares++; $display("FAIL rsth_first_grant trig=%b vout=%b required 0001 0", s_trig, s_vout);
    end
    pieo_ready_for_deq = '0; post_deq_ready = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_drop();
    test_timeout();
    test_hold();
    test_spurious();
    test_reset_in_hold();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++; $display("FAIL sb_leftover got=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
